// File: rtl/unified_line_mem.sv
// Single-port 64-bit line store for cache evict/fill traffic with a fixed access latency.
// One request at a time: IDLE accepts, BUSY counts down, DONE pulses rdy.
module unified_line_mem #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 2048,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic          we,
    input  logic [63:0]   wdata,
    output logic [63:0]   rd_data,
    output logic          rdy,
    output logic          busy,
    output logic          proto_err,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_wdata;
    logic          r_is_wr;
    logic [63:0]   r_rd_data;
    logic [15:0]   r_rd_cnt;
    logic [15:0]   r_wr_cnt;
    logic          w_accept;
    logic          w_access;

    logic [63:0]   r_mem [DEPTH];

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                if (re || we) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Address, data and op are captured at accept so the initiator may wander during BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_is_wr  <= 1'b0;
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_is_wr <= we;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == DONE) begin
                if (r_is_wr) begin
                    if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
                end else begin
                    if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
                end
            end
        end
    end

    // Array has no reset so it maps onto block RAM and survives a reset pulse.
    always_ff @(posedge clk) begin
        if (w_access && r_is_wr) r_mem[r_addr] <= r_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_rd_data <= 64'd0;
        else if (w_access && !r_is_wr)   r_rd_data <= r_mem[r_addr];
    end

    assign rd_data   = r_rd_data;
    assign rdy       = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign proto_err = rst_n && (r_state == IDLE) && re && we;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;
endmodule

// File: tb/tb_unified_line_mem.sv
// Bench for unified_line_mem: LATENCY=4 instance for function tests, LATENCY=1 for saturation.
module tb_unified_line_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst1_n;
    logic [10:0] addr4, addr1;
    logic        re4, we4, re1, we1;
    logic [63:0] wdata4, wdata1, rd_data4, rd_data1;
    logic        rdy4, busy4, perr4, rdy1, busy1, perr1;
    logic [15:0] rdc4, wrc4, rdc1, wrc1;

    unified_line_mem #(.LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .addr(addr4), .re(re4), .we(we4), .wdata(wdata4),
        .rd_data(rd_data4), .rdy(rdy4), .busy(busy4), .proto_err(perr4),
        .rd_cnt(rdc4), .wr_cnt(wrc4)
    );

    unified_line_mem #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .addr(addr1), .re(re1), .we(we1), .wdata(wdata1),
        .rd_data(rd_data1), .rdy(rdy1), .busy(busy1), .proto_err(perr1),
        .rd_cnt(rdc1), .wr_cnt(wrc1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: line contents, last completed read, completion counts.
    logic [63:0] model_mem [2048];
    logic [63:0] exp_rd  = 64'd0;
    int          exp_rdc = 0;
    int          exp_wrc = 0;

    task automatic idle_wait();
        if (rdy4 === 1'b1) begin @(posedge clk); #1; end
    endtask

    // mode 0: plain; mode 1: scramble addr/wdata mid-BUSY; mode 2: drop re/we mid-BUSY
    task automatic do_op(input bit is_wr, input bit both, input logic [10:0] a,
                         input logic [63:0] d, input int mode,
                         output int lat, output bit perr);
        int k;
        idle_wait();
        addr4  = a;
        wdata4 = d;
        we4    = is_wr | both;
        re4    = ~is_wr | both;
        #1;
        perr = perr4;
        lat  = -1;
        k    = 0;
        while (k < 40 && lat < 0) begin
            @(posedge clk); #1;
            k++;
            if (mode == 1 && k == 2) begin addr4 = a ^ 11'h030; wdata4 = ~d; end
            if (mode == 2 && k == 1) begin re4 = 1'b0; we4 = 1'b0; end
            if (rdy4 === 1'b1) lat = k;
        end
        re4 = 1'b0;
        we4 = 1'b0;
        if (lat > 0) begin
            if (is_wr | both) begin model_mem[a] = d; exp_wrc++; end
            else begin exp_rd = model_mem[a]; exp_rdc++; end
        end
        $display("txn %s addr=%03h data=%016h lat=%0d perr=%0d rd_data=%016h",
                 (is_wr | both) ? "WR" : "RD", a, d, lat, perr, rd_data4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0;
        addr4 = '0; re4 = 1'b0; we4 = 1'b0; wdata4 = '0;
        addr1 = '0; re1 = 1'b0; we1 = 1'b0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy4 !== 1'b0)      begin bad++; $display("FAIL reset_rdy: got %b want 0", rdy4); end
        total++; if (busy4 !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy4); end
        total++; if (perr4 !== 1'b0)     begin bad++; $display("FAIL reset_perr: got %b want 0", perr4); end
        total++; if (rd_data4 !== 64'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data4); end
        total++; if (rdc4 !== 16'd0)     begin bad++; $display("FAIL reset_rd_cnt: got %h want 0", rdc4); end
        total++; if (wrc4 !== 16'd0)     begin bad++; $display("FAIL reset_wr_cnt: got %h want 0", wrc4); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat; bit perr;
        do_op(1'b1, 1'b0, 11'h005, 64'hDEAD_BEEF_0123_4567, 0, lat, perr);
        total++; if (lat != 5)    begin bad++; $display("FAIL wr_latency: got %0d want 5", lat); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL wr_perr: got %b want 0", perr); end
        idle_wait();
        total++; if (wrc4 !== 16'(exp_wrc)) begin bad++; $display("FAIL wr_cnt_one: got %0d want %0d", wrc4, exp_wrc); end
        do_op(1'b0, 1'b0, 11'h005, 64'd0, 0, lat, perr);
        total++; if (lat != 5) begin bad++; $display("FAIL rd_latency: got %0d want 5", lat); end
        total++; if (rd_data4 !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL rd_data_005: got %h want DEADBEEF01234567", rd_data4); end
        idle_wait();
        total++; if (rdc4 !== 16'd1) begin bad++; $display("FAIL rd_cnt_one: got %0d want 1", rdc4); end
        // A write must leave the read register alone.
        do_op(1'b1, 1'b0, 11'h100, {$urandom, $urandom}, 0, lat, perr);
        total++; if (rd_data4 !== exp_rd) begin bad++; $display("FAIL rd_hold_on_write: got %h want %h", rd_data4, exp_rd); end
    endtask

    task automatic test_back_to_back();
        int lat; bit perr;
        logic [63:0] line_a;
        line_a = {$urandom, $urandom};
        do_op(1'b1, 1'b0, 11'h000, {$urandom, $urandom}, 0, lat, perr);
        do_op(1'b1, 1'b0, 11'h7FF, line_a, 0, lat, perr);
        do_op(1'b0, 1'b0, 11'h000, 64'd0, 0, lat, perr);
        total++; if (lat != 5) begin bad++; $display("FAIL b2b_fill_latency: got %0d want 5", lat); end
        total++; if (rd_data4 !== model_mem[0]) begin bad++; $display("FAIL b2b_fill_data: got %h want %h", rd_data4, model_mem[0]); end
        do_op(1'b0, 1'b0, 11'h7FF, 64'd0, 0, lat, perr);
        total++; if (rd_data4 !== line_a) begin bad++; $display("FAIL b2b_evict_data: got %h want %h", rd_data4, line_a); end
    endtask

    task automatic test_addr_change();
        int lat; bit perr;
        logic [63:0] line_b, line_c;
        line_b = {$urandom, $urandom};
        line_c = {$urandom, $urandom};
        do_op(1'b1, 1'b0, 11'h020, line_b, 0, lat, perr);
        do_op(1'b1, 1'b0, 11'h010, line_c, 1, lat, perr);
        total++; if (lat != 5) begin bad++; $display("FAIL chg_latency: got %0d want 5", lat); end
        do_op(1'b0, 1'b0, 11'h010, 64'd0, 0, lat, perr);
        total++; if (rd_data4 !== line_c) begin bad++; $display("FAIL chg_line_010: got %h want %h", rd_data4, line_c); end
        do_op(1'b0, 1'b0, 11'h020, 64'd0, 0, lat, perr);
        total++; if (rd_data4 !== line_b) begin bad++; $display("FAIL chg_line_020: got %h want %h", rd_data4, line_b); end
    endtask

    task automatic test_drop_request();
        int lat; bit perr;
        logic [63:0] line_d;
        line_d = {$urandom, $urandom};
        do_op(1'b1, 1'b0, 11'h030, line_d, 2, lat, perr);
        total++; if (lat != 5) begin bad++; $display("FAIL drop_wr_latency: got %0d want 5", lat); end
        do_op(1'b0, 1'b0, 11'h030, 64'd0, 2, lat, perr);
        total++; if (lat != 5) begin bad++; $display("FAIL drop_rd_latency: got %0d want 5", lat); end
        total++; if (rd_data4 !== line_d) begin bad++; $display("FAIL drop_rd_data: got %h want %h", rd_data4, line_d); end
    endtask

    task automatic test_both();
        int lat; bit perr;
        logic [63:0] line_e;
        line_e = {$urandom, $urandom};
        do_op(1'b0, 1'b1, 11'h003, line_e, 0, lat, perr);
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL both_perr: got %b want 1", perr); end
        total++; if (lat != 5)      begin bad++; $display("FAIL both_latency: got %0d want 5", lat); end
        idle_wait();
        total++; if (perr4 !== 1'b0) begin bad++; $display("FAIL both_perr_pulse: got %b want 0", perr4); end
        total++; if (wrc4 !== 16'(exp_wrc)) begin bad++; $display("FAIL both_wr_cnt: got %0d want %0d", wrc4, exp_wrc); end
        total++; if (rdc4 !== 16'(exp_rdc)) begin bad++; $display("FAIL both_rd_cnt: got %0d want %0d", rdc4, exp_rdc); end
        do_op(1'b0, 1'b0, 11'h003, 64'd0, 0, lat, perr);
        total++; if (rd_data4 !== line_e) begin bad++; $display("FAIL both_data: got %h want %h", rd_data4, line_e); end
    endtask

    task automatic test_random();
        int lat; bit perr;
        logic [10:0] a;
        bit is_wr;
        for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 11'h200 + 11'(i), {$urandom, $urandom}, 0, lat, perr);
        for (int i = 0; i < 40; i++) begin
            a     = 11'h200 + 11'($urandom_range(0, 15));
            is_wr = 1'($urandom);
            do_op(is_wr, 1'b0, a, {$urandom, $urandom}, int'($urandom_range(0, 2)), lat, perr);
            total++; if (lat != 5) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 5", i, lat); end
            total++; if (rd_data4 !== exp_rd) begin bad++; $display("FAIL rand_rd_data[%0d]: got %h want %h", i, rd_data4, exp_rd); end
        end
        idle_wait();
        total++; if (rdc4 !== 16'(exp_rdc)) begin bad++; $display("FAIL rand_rd_cnt: got %0d want %0d", rdc4, exp_rdc); end
        total++; if (wrc4 !== 16'(exp_wrc)) begin bad++; $display("FAIL rand_wr_cnt: got %0d want %0d", wrc4, exp_wrc); end
    endtask

    task automatic test_reset_abort();
        int lat; bit perr;
        int rdy_seen;
        logic [63:0] line_f;
        line_f = {$urandom, $urandom};
        do_op(1'b1, 1'b0, 11'h044, line_f, 0, lat, perr);
        idle_wait();
        addr4 = 11'h044; wdata4 = ~line_f; we4 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++; if (rdy4 !== 1'b0)      begin bad++; $display("FAIL abort_rdy: got %b want 0", rdy4); end
        total++; if (busy4 !== 1'b0)     begin bad++; $display("FAIL abort_busy: got %b want 0", busy4); end
        total++; if (perr4 !== 1'b0)     begin bad++; $display("FAIL abort_perr: got %b want 0", perr4); end
        total++; if (rd_data4 !== 64'd0) begin bad++; $display("FAIL abort_rd_data: got %h want 0", rd_data4); end
        total++; if (rdc4 !== 16'd0)     begin bad++; $display("FAIL abort_rd_cnt: got %0d want 0", rdc4); end
        total++; if (wrc4 !== 16'd0)     begin bad++; $display("FAIL abort_wr_cnt: got %0d want 0", wrc4); end
        we4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_rd = 64'd0; exp_rdc = 0; exp_wrc = 0;
        rdy_seen = 0;
        repeat (10) begin @(posedge clk); #1; if (rdy4 === 1'b1) rdy_seen++; end
        total++; if (rdy_seen != 0) begin bad++; $display("FAIL abort_no_rdy: got %0d pulses want 0", rdy_seen); end
        do_op(1'b0, 1'b0, 11'h044, 64'd0, 0, lat, perr);
        total++; if (rd_data4 !== line_f) begin bad++; $display("FAIL abort_line_044: got %h want %h", rd_data4, line_f); end
        idle_wait();
        total++; if (rdc4 !== 16'd1) begin bad++; $display("FAIL abort_rd_cnt_after: got %0d want 1", rdc4); end
    endtask

    task automatic test_saturate();
        int k, lat_bad, data_bad;
        bit got;
        logic [63:0] line_g;
        line_g = {$urandom, $urandom};
        lat_bad = 0; data_bad = 0;
        rst1_n = 1'b1;
        @(posedge clk); #1;
        addr1 = 11'h009; wdata1 = line_g; we1 = 1'b1;
        k = 0; got = 1'b0;
        while (k < 10 && !got) begin @(posedge clk); #1; k++; if (rdy1 === 1'b1) got = 1'b1; end
        we1 = 1'b0;
        total++; if (!got || k != 2) begin bad++; $display("FAIL l1_wr_latency: got %0d want 2", got ? k : -1); end
        for (int i = 0; i < 65540; i++) begin
            if (rdy1 === 1'b1) begin @(posedge clk); #1; end
            if (i == 1000) begin
                total++; if (rdc1 !== 16'd1000) begin bad++; $display("FAIL l1_rd_cnt_1000: got %0d want 1000", rdc1); end
            end
            if (i == 65534) begin
                total++; if (rdc1 !== 16'hFFFE) begin bad++; $display("FAIL l1_rd_cnt_fffe: got %h want fffe", rdc1); end
            end
            if (i == 65535) begin
                total++; if (rdc1 !== 16'hFFFF) begin bad++; $display("FAIL l1_rd_cnt_ffff: got %h want ffff", rdc1); end
            end
            addr1 = 11'h009; re1 = 1'b1;
            k = 0; got = 1'b0;
            while (k < 10 && !got) begin @(posedge clk); #1; k++; if (rdy1 === 1'b1) got = 1'b1; end
            re1 = 1'b0;
            if (!got || k != 2) lat_bad++;
            if (rd_data1 !== line_g) data_bad++;
        end
        @(posedge clk); #1;
        $display("txn L1 reads=65540 lat_bad=%0d data_bad=%0d rd_cnt=%h", lat_bad, data_bad, rdc1);
        total++; if (lat_bad != 0)     begin bad++; $display("FAIL l1_rd_latency: got %0d late reads want 0", lat_bad); end
        total++; if (data_bad != 0)    begin bad++; $display("FAIL l1_rd_data: got %0d bad reads want 0", data_bad); end
        total++; if (rdc1 !== 16'hFFFF) begin bad++; $display("FAIL l1_rd_cnt_sat: got %h want ffff", rdc1); end
        total++; if (wrc1 !== 16'd1)   begin bad++; $display("FAIL l1_wr_cnt: got %0d want 1", wrc1); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_addr_change();
        test_drop_request();
        test_both();
        test_random();
        test_reset_abort();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
